vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; successor to the fixed 640-wide h-only controller.
//  Runs both horizontal and vertical counters from osc_clk through a pixel-rate clock enable.
//  Emits programmable-polarity H_SYNC/V_SYNC, VIDEO_ON, PIXEL_X/PIXEL_Y and frame/line strobes.
//  Sits between the top-level oscillator and the pixel/colour datapath.
// PARAMETERS
//  CNT_W     11  width of h/v counters and PIXEL_X/PIXEL_Y; must hold H_TOTAL-1 and V_TOTAL-1
//  H_ACTIVE  640 visible pixels per line
//  H_FP      16  horizontal front porch, pixels
//  H_SW      96  horizontal sync width, pixels
//  H_BP      48  horizontal back porch, pixels
//  V_ACTIVE  480 visible lines per frame
//  V_FP      10  vertical front porch, lines
//  V_SW      2   vertical sync width, lines
//  V_BP      33  vertical back porch, lines
//  HS_POL    0   H_SYNC active level (0 = active-low)
//  VS_POL    0   V_SYNC active level (0 = active-low)
//  PIX_DIV   1   osc_clk cycles per pixel, >=1
// PORTS
//  osc_clk      in   1      system clock
//  RESET        in   1      asynchronous active-low reset
//  ENABLE       in   1      1 = run; 0 = synchronous hold-in-reset of counters and outputs
//  PIX_CE       out  1      pixel clock enable, one osc_clk wide every PIX_DIV cycles
//  H_SYNC       out  1      horizontal sync, polarity HS_POL
//  V_SYNC       out  1      vertical sync, polarity VS_POL
//  VIDEO_ON     out  1      1 while PIXEL_X<H_ACTIVE and PIXEL_Y<V_ACTIVE
//  PIXEL_X      out  CNT_W  horizontal position of current pixel
//  PIXEL_Y      out  CNT_W  vertical position of current line
//  LINE_END     out  1      1 for the single PIX_CE at PIXEL_X==H_TOTAL-1
//  FRAME_START  out  1      1 for the single PIX_CE at PIXEL_X==0, PIXEL_Y==0
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SW+H_BP; V_TOTAL likewise. All arithmetic unsigned, CNT_W bits.
//  - Reset (RESET low, async): div counter, h_cnt, v_cnt = 0; PIX_CE=0, VIDEO_ON=0,
//    LINE_END=0, FRAME_START=0, PIXEL_X=PIXEL_Y=0, H_SYNC=~HS_POL, V_SYNC=~VS_POL.
//  - ENABLE low: same values as reset, applied synchronously; takes priority over counting.
//  - Divider: counts 0..PIX_DIV-1; PIX_CE=1 on cycle where it equals PIX_DIV-1 (PIX_DIV=1: every cycle).
//  - On PIX_CE: h_cnt wraps H_TOTAL-1 -> 0, else +1; on that wrap v_cnt wraps V_TOTAL-1 -> 0, else +1.
//  - Outputs registered from h_cnt/v_cnt: one osc_clk latency; all outputs mutually aligned.
//  - PIXEL_X/PIXEL_Y, VIDEO_ON, syncs and strobes change only on the cycle after a PIX_CE.
//  - H_SYNC active when H_ACTIVE+H_FP <= PIXEL_X < H_ACTIVE+H_FP+H_SW.
//  - V_SYNC active when V_ACTIVE+V_FP <= PIXEL_Y < V_ACTIVE+V_FP+V_SW; changes with PIXEL_Y.
//  - LINE_END, FRAME_START: exactly one osc_clk wide per occurrence, regardless of PIX_DIV.
//  - Simultaneous line and frame wrap: v_cnt wraps on same PIX_CE as h_cnt; FRAME_START follows.
//  - After reset/ENABLE release, first PIX_CE cycle presents (0,0) with FRAME_START=1.
//  - Reset or ENABLE drop mid-frame: immediate restart from (0,0); no partial sync pulse kept.
//  - No state outside the listed counters; no combinational path input->output.
// TESTING (bench params: H 8/2/3/2 ->H_TOTAL=15, V 4/1/2/1 ->V_TOTAL=8, PIX_DIV=1 unless noted)
//  1 Reset release, ENABLE=1 -> FRAME_START=1 with X=0,Y=0; X counts 0..14 then 0; LINE_END at X=14.
//  2 Full line -> H_SYNC low exactly for X=10,11,12; VIDEO_ON=1 for X=0..7 on Y=0..3, else 0.
//  3 Full frame -> Y 0..7 wraps to 0 after X=14,Y=7; V_SYNC low for Y=5,6; FRAME_START once/120 px.
//  4 PIX_DIV=3 -> PIX_CE every 3rd cycle; X held 3 cycles each; LINE_END/FRAME_START 1 cycle wide.
//  5 HS_POL=1,VS_POL=1 -> syncs idle 0 after reset, high during same windows as scenario 2/3.
//  6 RESET low at X=11,Y=5 (mid sync) -> outputs at reset values immediately; restart at (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v position counters and
// registered sync/blanking/strobe outputs, all aligned one osc_clk after the counters.
module vga_timing_gen #(
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SW     = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SW     = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_DIV  = 1
) (
    input  logic             osc_clk,
    input  logic             RESET,
    input  logic             ENABLE,
    output logic             PIX_CE,
    output logic             H_SYNC,
    output logic             V_SYNC,
    output logic             VIDEO_ON,
    output logic [CNT_W-1:0] PIXEL_X,
    output logic [CNT_W-1:0] PIXEL_Y,
    output logic             LINE_END,
    output logic             FRAME_START
);

    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SW + H_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SW);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SW + V_BP - 1);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SW);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             pix_ce_q, pix_ce_d, hs_q, hs_d, vs_q, vs_d, video_q, video_d;
    logic             line_end_q, line_end_d, frame_start_q, frame_start_d;
    logic             ce;

    always_comb begin
        ce            = (div_q == DIV_LAST);
        div_d         = div_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        video_d       = video_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        pix_ce_d      = 1'b0;
        line_end_d    = 1'b0;
        frame_start_d = 1'b0;

        if (!ENABLE) begin
            div_d   = '0;
            h_cnt_d = '0;
            v_cnt_d = '0;
            x_d     = '0;
            y_d     = '0;
            video_d = 1'b0;
            hs_d    = ~HS_POL;
            vs_d    = ~VS_POL;
        end else begin
            div_d = ce ? '0 : div_q + DIV_W'(1);
            if (ce) begin
                // Counters hold the pixel about to be presented; outputs latch it on this edge.
                h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + CNT_W'(1);
                if (h_cnt_q == H_LAST) begin
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
                end
                pix_ce_d      = 1'b1;
                x_d           = h_cnt_q;
                y_d           = v_cnt_q;
                video_d       = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
                hs_d          = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
                vs_d          = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
                line_end_d    = (h_cnt_q == H_LAST);
                frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            end
        end
    end

    always_ff @(posedge osc_clk or negedge RESET) begin
        if (!RESET) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            video_q       <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            pix_ce_q      <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_q       <= video_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            pix_ce_q      <= pix_ce_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_CE      = pix_ce_q;
    assign H_SYNC      = hs_q;
    assign V_SYNC      = vs_q;
    assign VIDEO_ON    = video_q;
    assign PIXEL_X     = x_q;
    assign PIXEL_Y     = y_q;
    assign LINE_END    = line_end_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (divide-by-1, divide-by-3, inverted sync
// polarity) share stimulus and are checked against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int CW = 11;
    localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    logic          ce  [3];
    logic          hs  [3];
    logic          vs  [3];
    logic          vid [3];
    logic          le  [3];
    logic          fs  [3];
    logic [CW-1:0] px  [3];
    logic [CW-1:0] py  [3];

    int divs [3] = '{1, 3, 1};
    bit polh [3] = '{1'b0, 1'b0, 1'b1};
    bit polv [3] = '{1'b0, 1'b0, 1'b1};

    int k = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.CNT_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SW(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SW(VSW), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
        .PIX_DIV(1)) dut_a (
        .osc_clk(clk), .RESET(rst_n), .ENABLE(en), .PIX_CE(ce[0]), .H_SYNC(hs[0]),
        .V_SYNC(vs[0]), .VIDEO_ON(vid[0]), .PIXEL_X(px[0]), .PIXEL_Y(py[0]),
        .LINE_END(le[0]), .FRAME_START(fs[0]));

    vga_timing_gen #(.CNT_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SW(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SW(VSW), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
        .PIX_DIV(3)) dut_b (
        .osc_clk(clk), .RESET(rst_n), .ENABLE(en), .PIX_CE(ce[1]), .H_SYNC(hs[1]),
        .V_SYNC(vs[1]), .VIDEO_ON(vid[1]), .PIXEL_X(px[1]), .PIXEL_Y(py[1]),
        .LINE_END(le[1]), .FRAME_START(fs[1]));

    vga_timing_gen #(.CNT_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SW(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SW(VSW), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1),
        .PIX_DIV(1)) dut_c (
        .osc_clk(clk), .RESET(rst_n), .ENABLE(en), .PIX_CE(ce[2]), .H_SYNC(hs[2]),
        .V_SYNC(vs[2]), .VIDEO_ON(vid[2]), .PIXEL_X(px[2]), .PIXEL_Y(py[2]),
        .LINE_END(le[2]), .FRAME_START(fs[2]));

    // k = enabled clock edges since the last reset/disable; the n-th pixel enable
    // lands on edge n*d and presents raster position (n-1) mod HT*VT.
    function automatic logic [27:0] expect_vec(int kk, int d, bit ph, bit pv);
        int  n, p, x, y;
        bit  pce, hsa, vsa, von;
        n = kk / d;
        if (n == 0) return {1'b0, ~ph, ~pv, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0};
        pce = (kk % d) == 0;
        p   = (n - 1) % (HT * VT);
        x   = p % HT;
        y   = p / HT;
        hsa = (x >= HA + HF) && (x < HA + HF + HSW);
        vsa = (y >= VA + VF) && (y < VA + VF + VSW);
        von = (x < HA) && (y < VA);
        return {pce, hsa ? ph : ~ph, vsa ? pv : ~pv, von, pce && (x == HT - 1),
                pce && (p == 0), 11'(x), 11'(y)};
    endfunction

    task automatic check_all();
        logic [27:0] obs, exp;
        for (int i = 0; i < 3; i++) begin
            exp = expect_vec(k, divs[i], polh[i], polv[i]);
            obs = {ce[i], hs[i], vs[i], vid[i], le[i], fs[i], px[i], py[i]};
            vectors++;
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL dut%0d k=%0d observed=%h expected=%h", i, k, obs, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n || !en) k = 0;
        else k++;
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        k = 0;
        #1;
        check_all();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        #12;
        check_all();
        repeat (3) step();

        // Release and run past a full frame on every instance.
        rst_n = 1'b1;
        en = 1'b1;
        repeat (400) step();

        // Synchronous hold via ENABLE, then restart.
        en = 1'b0;
        repeat (2) step();
        en = 1'b1;
        repeat (50) step();

        // Async reset landing at X=11, Y=5 on the divide-by-1 instance.
        pulse_reset();
        repeat (5 * HT + 11 + 1) step();
        #2;
        rst_n = 1'b0;
        k = 0;
        #1;
        check_all();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (40) step();

        // Random ENABLE drops and async reset pulses.
        repeat (3000) begin
            r = $urandom_range(0, 799);
            if (r < 2) begin
                en = 1'b0;
            end else if (r == 2) begin
                pulse_reset();
                en = 1'b1;
            end else begin
                en = 1'b1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
